dmem_access_unit: RTL and testbench

- Memory-stage load/store engine. It sits between the Execute→Memory pipeline register and the data memory port.
- Issues DMEM requests and waits on the request/response handshake, raising stallControl toward the hazard unit while an access is in flight.
- Formats load data, flags misaligned, bad-funct3 and bus-error accesses as illegal, and owns the Memory→Writeback pipeline register under the hazard unit's stall/flush control.

---
 rtl/dmem_access_unit_pkg.sv | 44 ++++
 rtl/dmem_access_unit_load_store_align.sv | 45 ++++
 rtl/dmem_access_unit.sv | 175 +++++++++++++++++
 tb/tb_dmem_access_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_unit_pkg.sv
// Shared types for the memory-stage load/store engine: FSM states, funct3 encodings,
// the pipeline control struct and the Memory->Writeback payload.
package dmem_access_unit_pkg;

    typedef struct packed {
        logic stall;
        logic flush;
    } control_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] data;
    } mw_payload_t;

    function automatic logic funct3_legal(input logic [2:0] f3, input logic is_load);
        if (is_load) return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        return f3 inside {F3_SB, F3_SH, F3_SW};
    endfunction

    function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_store_align.sv
// Combinational byte-lane handling: store strobe/data replication and load extract/extend.
module load_store_align
    import dmem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] read_data,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);
    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = read_data >> {offset, 3'b000};

        // Sub-word stores replicate across the word so the strobes alone pick the lane.
        case (funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << offset;
                wdata = {(XLEN/8){store_data[7:0]}};
            end
            2'b01: begin
                wstrb = 4'b0011 << offset;
                wdata = {(XLEN/16){store_data[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
        endcase

        case (funct3)
            F3_LB:   load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store engine: DMEM request/response handshake, load formatting and the
// Memory->Writeback register. Define DMEM_TIMEOUT_EN to enable the WAIT-state watchdog.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            em_valid,
    input  logic            em_is_load,
    input  logic            em_is_store,
    input  logic [2:0]      em_funct3,
    input  logic [XLEN-1:0] em_address,
    input  logic [XLEN-1:0] em_store_data,
    input  logic [4:0]      em_rd,
    input  logic            em_reg_write,
    input  logic [XLEN-1:0] em_result,
    input  control_t        em_control,
    input  control_t        mw_control,
    output logic            stall_control,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic            dmem_req_we,
    output logic [3:0]      dmem_req_wstrb,
    output logic [XLEN-1:0] dmem_req_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_rdata,
    input  logic            dmem_rsp_error,
    output logic            mw_valid,
    output logic            mw_illegal,
    output logic            mw_reg_write,
    output logic [4:0]      mw_rd,
    output logic [XLEN-1:0] mw_data
);
    mem_state_t      state;
    logic            is_mem, bad_op, start;
    logic [XLEN-1:0] cap_addr, cap_store_data, rsp_data;
    logic [2:0]      cap_funct3;
    logic [4:0]      cap_rd;
    logic            cap_reg_write, cap_is_load, rsp_err;
    logic [3:0]      lane_wstrb;
    logic [XLEN-1:0] lane_wdata, load_data;
    mw_payload_t     mw_q, mw_next;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 9) ? $clog2(TIMEOUT_CYCLES + 1) : 9;
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_comb begin
        is_mem = em_is_load | em_is_store;
        bad_op = is_mem && (!funct3_legal(em_funct3, em_is_load) ||
                            access_misaligned(em_funct3, em_address[1:0]));
        start  = (state == S_IDLE) && em_valid && is_mem && !bad_op && !em_control.flush;
    end

    assign stall_control  = reset && (start || state inside {S_REQ, S_WAIT, S_DRAIN});
    assign dmem_req_valid = (state == S_REQ) && !em_control.flush;
    assign dmem_req_addr  = {cap_addr[XLEN-1:2], 2'b00};
    assign dmem_req_we    = !cap_is_load;
    assign dmem_req_wstrb = cap_is_load ? 4'b0000 : lane_wstrb;
    assign dmem_req_wdata = lane_wdata;

    load_store_align #(.XLEN(XLEN)) u_align (
        .funct3     (cap_funct3),
        .offset     (cap_addr[1:0]),
        .store_data (cap_store_data),
        .read_data  (rsp_data),
        .wstrb      (lane_wstrb),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

    always_comb begin
        mw_next = '0;
        case (state)
            // A stalled EM stage keeps its op, so only pass it when EM actually advances.
            S_IDLE: if (!start && !em_control.flush && !em_control.stall) begin
                mw_next.valid     = em_valid;
                mw_next.illegal   = em_valid && bad_op;
                mw_next.reg_write = em_valid && em_reg_write && !bad_op;
                mw_next.rd        = em_rd;
                mw_next.data      = bad_op ? '0 : em_result;
            end
            S_DONE: begin
                mw_next.valid     = 1'b1;
                mw_next.illegal   = rsp_err;
                mw_next.reg_write = cap_reg_write && cap_is_load && !rsp_err;
                mw_next.rd        = cap_rd;
                mw_next.data      = (cap_is_load && !rsp_err) ? load_data : '0;
            end
            default: mw_next = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= S_IDLE;
            cap_addr       <= '0;
            cap_store_data <= '0;
            cap_funct3     <= '0;
            cap_rd         <= '0;
            cap_reg_write  <= 1'b0;
            cap_is_load    <= 1'b1;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            mw_q           <= '0;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cap_addr       <= em_address;
                    cap_store_data <= em_store_data;
                    cap_funct3     <= em_funct3;
                    cap_rd         <= em_rd;
                    cap_reg_write  <= em_reg_write;
                    cap_is_load    <= em_is_load;
                    state          <= S_REQ;
                end
                S_REQ: begin
                    if (em_control.flush) begin
                        state <= S_IDLE;
                    end else if (dmem_req_ready) begin
                        state <= S_WAIT;
`ifdef DMEM_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (dmem_rsp_valid) begin
                        rsp_data <= dmem_rsp_rdata;
                        rsp_err  <= dmem_rsp_error;
                        state    <= em_control.flush ? S_IDLE : S_DONE;
                    end else if (em_control.flush) begin
                        state <= S_DRAIN;
`ifdef DMEM_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_DRAIN: if (dmem_rsp_valid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (mw_control.flush) begin
                mw_q.valid <= 1'b0;
            end else if (!mw_control.stall) begin
                mw_q <= mw_next;
            end
        end
    end

    assign mw_valid     = mw_q.valid;
    assign mw_illegal   = mw_q.illegal;
    assign mw_reg_write = mw_q.reg_write;
    assign mw_rd        = mw_q.rd;
    assign mw_data      = mw_q.data;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit (timeout case built only with DMEM_TIMEOUT_EN).
module tb_dmem_access_unit;
    import dmem_access_unit_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        em_valid, em_is_load, em_is_store, em_reg_write;
    logic [2:0]  em_funct3;
    logic [31:0] em_address, em_store_data, em_result;
    logic [4:0]  em_rd;
    control_t    em_control, mw_control;
    logic        stall_control, dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_rsp_rdata, mw_data;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_rsp_valid, dmem_rsp_error;
    logic        mw_valid, mw_illegal, mw_reg_write;
    logic [4:0]  mw_rd;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          stall_cnt, hs_cyc, mw_cyc;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_wstrb;
    logic        obs_we, mw_seen;

    dmem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .em_valid       (em_valid),
        .em_is_load     (em_is_load),
        .em_is_store    (em_is_store),
        .em_funct3      (em_funct3),
        .em_address     (em_address),
        .em_store_data  (em_store_data),
        .em_rd          (em_rd),
        .em_reg_write   (em_reg_write),
        .em_result      (em_result),
        .em_control     (em_control),
        .mw_control     (mw_control),
        .stall_control  (stall_control),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_wstrb (dmem_req_wstrb),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .dmem_rsp_error (dmem_rsp_error),
        .mw_valid       (mw_valid),
        .mw_illegal     (mw_illegal),
        .mw_reg_write   (mw_reg_write),
        .mw_rd          (mw_rd),
        .mw_data        (mw_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one EM op, plays a ready=1 memory that answers one cycle after the handshake
    // (when respond=1), holds EM while stalled and records what the DUT did per cycle.
    task automatic mem_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input logic err, input logic respond);
        logic drop;
        em_valid = 1'b1; em_is_load = ld; em_is_store = st; em_funct3 = f3;
        em_address = addr; em_store_data = sdata; em_rd = 5'd7; em_reg_write = 1'b1;
        dmem_req_ready = 1'b1;
        stall_cnt = 0; hs_cyc = -1; mw_cyc = -1; drop = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            dmem_rsp_valid = respond && hs_cyc >= 0 && cyc == hs_cyc + 1;
            dmem_rsp_rdata = rdata;
            dmem_rsp_error = err;
            if (drop) em_valid = 1'b0;
            #1;
            if (stall_control) stall_cnt++;
            else drop = 1'b1;
            if (dmem_req_valid && dmem_req_ready && hs_cyc < 0) begin
                hs_cyc = cyc; obs_addr = dmem_req_addr; obs_we = dmem_req_we;
                obs_wstrb = dmem_req_wstrb; obs_wdata = dmem_req_wdata;
            end
            if (mw_valid) begin
                mw_cyc = cyc;
                break;
            end
            step();
        end
        dmem_rsp_valid = 1'b0; dmem_rsp_error = 1'b0; em_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b0;
        em_valid = 1'b1; em_is_load = 1'b1; em_is_store = 1'b0; em_funct3 = F3_LW;
        em_address = 32'h100; em_store_data = '0; em_rd = '0; em_reg_write = 1'b1;
        em_result = '0; em_control = '0; mw_control = '0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0; dmem_rsp_error = 1'b0;
        step(); step();
        check("reset_stall", 32'(stall_control), 32'd0);
        check("reset_req_valid", 32'(dmem_req_valid), 32'd0);
        check("reset_mw_valid", 32'(mw_valid), 32'd0);
        check("reset_mw_illegal", 32'(mw_illegal), 32'd0);
        check("reset_mw_data", mw_data, 32'd0);
        reset = 1'b1; em_valid = 1'b0;
        step();

        // Stray response while idle must do nothing.
        dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h12345678;
        #1;
        check("stray_stall", 32'(stall_control), 32'd0);
        step();
        dmem_rsp_valid = 1'b0;
        check("stray_mw_valid", 32'(mw_valid), 32'd0);

        mem_op(1, 0, F3_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1);
        check("lw_stall_cycles", 32'(stall_cnt), 32'd3);
        check("lw_mw_cycle", 32'(mw_cyc), 32'd4);
        check("lw_req_addr", obs_addr, 32'h100);
        check("lw_req_we", 32'(obs_we), 32'd0);
        check("lw_mw_data", mw_data, 32'hDEADBEEF);
        check("lw_mw_rd", 32'(mw_rd), 32'd7);
        check("lw_mw_reg_write", 32'(mw_reg_write), 32'd1);
        check("lw_mw_illegal", 32'(mw_illegal), 32'd0);
        step();
        check("lw_mw_bubble_after", 32'(mw_valid), 32'd0);

        mem_op(1, 0, F3_LB, 32'h103, 32'h0, 32'h80FF1234, 0, 1);
        check("lb_req_addr", obs_addr, 32'h100);
        check("lb_mw_data", mw_data, 32'hFFFFFF80);
        step();
        mem_op(1, 0, F3_LBU, 32'h103, 32'h0, 32'h80FF1234, 0, 1);
        check("lbu_mw_data", mw_data, 32'h00000080);
        step();
        mem_op(1, 0, F3_LH, 32'h102, 32'h0, 32'h80FF1234, 0, 1);
        check("lh_mw_data", mw_data, 32'hFFFF80FF);
        step();
        mem_op(1, 0, F3_LHU, 32'h100, 32'h0, 32'h80FF9234, 0, 1);
        check("lhu_mw_data", mw_data, 32'h00009234);
        step();

        mem_op(0, 1, F3_SH, 32'h202, 32'h0000ABCD, 32'h0, 0, 1);
        check("sh_req_addr", obs_addr, 32'h200);
        check("sh_req_wstrb", 32'(obs_wstrb), 32'hC);
        check("sh_req_wdata", obs_wdata, 32'hABCDABCD);
        check("sh_req_we", 32'(obs_we), 32'd1);
        check("sh_mw_cycle", 32'(mw_cyc), 32'd4);
        check("sh_mw_reg_write", 32'(mw_reg_write), 32'd0);
        step();
        mem_op(0, 1, F3_SB, 32'h201, 32'h1234565A, 32'h0, 0, 1);
        check("sb_req_wstrb", 32'(obs_wstrb), 32'h2);
        check("sb_req_wdata", obs_wdata, 32'h5A5A5A5A);
        step();
        mem_op(0, 1, F3_SW, 32'h300, 32'h12345678, 32'h0, 0, 1);
        check("sw_req_wstrb", 32'(obs_wstrb), 32'hF);
        check("sw_req_wdata", obs_wdata, 32'h12345678);
        step();

        mem_op(1, 0, F3_LW, 32'h101, 32'h0, 32'h0, 0, 1);
        check("lw_mis_stall", 32'(stall_cnt), 32'd0);
        check("lw_mis_no_req", 32'(hs_cyc), 32'hFFFFFFFF);
        check("lw_mis_mw_cycle", 32'(mw_cyc), 32'd1);
        check("lw_mis_illegal", 32'(mw_illegal), 32'd1);
        check("lw_mis_reg_write", 32'(mw_reg_write), 32'd0);
        step();
        mem_op(1, 0, F3_LH, 32'h101, 32'h0, 32'h0, 0, 1);
        check("lh_mis_illegal", 32'(mw_illegal), 32'd1);
        step();
        mem_op(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1);
        check("ld_f3_illegal", 32'(mw_illegal), 32'd1);
        check("ld_f3_no_req", 32'(hs_cyc), 32'hFFFFFFFF);
        step();
        mem_op(0, 1, F3_LBU, 32'h100, 32'h0, 32'h0, 0, 1);
        check("st_f3_illegal", 32'(mw_illegal), 32'd1);
        step();

        em_result = 32'h000055AA;
        mem_op(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 1);
        check("alu_mw_cycle", 32'(mw_cyc), 32'd1);
        check("alu_mw_data", mw_data, 32'h000055AA);
        check("alu_mw_illegal", 32'(mw_illegal), 32'd0);
        check("alu_mw_reg_write", 32'(mw_reg_write), 32'd1);
        step();

        mem_op(1, 0, F3_LW, 32'h104, 32'h0, 32'hCAFEF00D, 1, 1);
        check("buserr_illegal", 32'(mw_illegal), 32'd1);
        check("buserr_reg_write", 32'(mw_reg_write), 32'd0);
        step();

        // MW register: stall holds, flush clears valid.
        em_valid = 1'b1; em_is_load = 1'b0; em_is_store = 1'b0; em_result = 32'h1111;
        step();
        check("mw_load_data", mw_data, 32'h1111);
        em_result = 32'h2222; mw_control.stall = 1'b1;
        step();
        check("mw_stall_hold", mw_data, 32'h1111);
        check("mw_stall_valid", 32'(mw_valid), 32'd1);
        mw_control = '0; mw_control.flush = 1'b1;
        step();
        check("mw_flush_valid", 32'(mw_valid), 32'd0);
        mw_control = '0; em_valid = 1'b0;
        step();

        // Flush while the request is still unaccepted: request withdrawn, nothing written back.
        em_valid = 1'b1; em_is_load = 1'b1; em_funct3 = F3_LW; em_address = 32'h408;
        dmem_req_ready = 1'b0;
        step();
        check("reqflush_req_valid", 32'(dmem_req_valid), 32'd1);
        step();
        check("reqflush_addr_hold", dmem_req_addr, 32'h408);
        em_control.flush = 1'b1;
        #1;
        check("reqflush_withdrawn", 32'(dmem_req_valid), 32'd0);
        step();
        em_control = '0; em_valid = 1'b0;
        #1;
        check("reqflush_stall", 32'(stall_control), 32'd0);
        check("reqflush_req_idle", 32'(dmem_req_valid), 32'd0);
        step();
        check("reqflush_mw_valid", 32'(mw_valid), 32'd0);

        // Flush in WAIT: stall stays up through DRAIN until the late response, no MW write.
        em_valid = 1'b1; em_is_load = 1'b1; em_funct3 = F3_LW; em_address = 32'h400;
        dmem_req_ready = 1'b1; mw_seen = 1'b0;
        step();
        mw_seen |= mw_valid;
        step();
        em_control.flush = 1'b1;
        #1;
        check("drain_wait_stall", 32'(stall_control), 32'd1);
        mw_seen |= mw_valid;
        step();
        em_control = '0; em_valid = 1'b0;
        check("drain_stall_1", 32'(stall_control), 32'd1);
        mw_seen |= mw_valid;
        step();
        check("drain_stall_2", 32'(stall_control), 32'd1);
        mw_seen |= mw_valid;
        step();
        dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hBAD0BAD0;
        #1;
        check("drain_stall_rsp", 32'(stall_control), 32'd1);
        mw_seen |= mw_valid;
        step();
        dmem_rsp_valid = 1'b0;
        check("drain_released", 32'(stall_control), 32'd0);
        mw_seen |= mw_valid;
        step();
        mw_seen |= mw_valid;
        check("drain_no_mw_write", 32'(mw_seen), 32'd0);

`ifdef DMEM_TIMEOUT_EN
        mem_op(1, 0, F3_LW, 32'h500, 32'h0, 32'h0, 0, 0);
        check("to_stall_cycles", 32'(stall_cnt), 32'd10);
        check("to_mw_cycle", 32'(mw_cyc), 32'd11);
        check("to_illegal", 32'(mw_illegal), 32'd1);
        check("to_reg_write", 32'(mw_reg_write), 32'd0);
        dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h0BADF00D;
        step();
        dmem_rsp_valid = 1'b0;
        check("to_late_rsp_stall", 32'(stall_control), 32'd0);
        check("to_late_rsp_mw", 32'(mw_valid), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
